// File: rtl/rv_writeback_pkg.sv
// rv_writeback_pkg
//   Shared definitions for the uRV write-back stage:
//   - load funct3 encodings (LDST_B/H/W/BU/HU)
//   - write-back FSM state encoding (exposed on the debug port)
//   Optional feature macro used by the files of this block: RV_WB_MUL_EN
package rv_writeback_pkg;

   localparam logic [2:0] LDST_B  = 3'b000;
   localparam logic [2:0] LDST_H  = 3'b001;
   localparam logic [2:0] LDST_W  = 3'b010;
   localparam logic [2:0] LDST_BU = 3'b100;
   localparam logic [2:0] LDST_HU = 3'b101;

   typedef enum logic [0:0] {
      ST_IDLE      = 1'b0,
      ST_LOAD_WAIT = 1'b1
   } wb_state_e;

endpackage

// File: rtl/rv_writeback_if.sv
// rv_writeback_if
//   Bundles every non-clock/reset signal of the write-back stage.
//   master : X stage / data memory side (drives x_*, dm_*, mul_*)
//   slave  : rv_writeback (drives w_stall_o, rf_*, dbg_state_o)
//   Handshake: there is no ready. An instruction presented with x_valid_i=1
//   is accepted on a rising edge where w_stall_o=0; while w_stall_o=1 the
//   producer must hold it. dm_load_done_i is a single-cycle data-valid
//   qualifier for dm_data_l_i and has no backpressure.
//   Optional: RV_WB_MUL_EN adds mul_result_i and x_mul_i.
interface rv_writeback_if;
   import rv_writeback_pkg::*;

   logic        x_valid_i;
   logic [4:0]  x_rd_i;
   logic [31:0] x_rd_value_i;
   logic        x_rd_write_i;
   logic        x_load_i;
   logic [2:0]  x_fun_i;
   logic [1:0]  x_dm_addr_i;
   logic [31:0] dm_data_l_i;
   logic        dm_load_done_i;
   logic        w_stall_o;
   logic [4:0]  rf_rd_o;
   logic [31:0] rf_rd_value_o;
   logic        rf_rd_store_o;
   logic        rf_bypass_write_o;
   logic [31:0] rf_bypass_value_o;
   wb_state_e   dbg_state_o;
`ifdef RV_WB_MUL_EN
   logic [31:0] mul_result_i;
   logic        x_mul_i;
`endif

   modport master (
`ifdef RV_WB_MUL_EN
      output mul_result_i, x_mul_i,
`endif
      output x_valid_i, x_rd_i, x_rd_value_i, x_rd_write_i, x_load_i,
      output x_fun_i, x_dm_addr_i, dm_data_l_i, dm_load_done_i,
      input  w_stall_o, rf_rd_o, rf_rd_value_o, rf_rd_store_o,
      input  rf_bypass_write_o, rf_bypass_value_o, dbg_state_o
   );

   modport slave (
`ifdef RV_WB_MUL_EN
      input  mul_result_i, x_mul_i,
`endif
      input  x_valid_i, x_rd_i, x_rd_value_i, x_rd_write_i, x_load_i,
      input  x_fun_i, x_dm_addr_i, dm_data_l_i, dm_load_done_i,
      output w_stall_o, rf_rd_o, rf_rd_value_o, rf_rd_store_o,
      output rf_bypass_write_o, rf_bypass_value_o, dbg_state_o
   );

endinterface

// File: rtl/rv_writeback_load_align.sv
// rv_load_align
//   Purely combinational load data aligner / extender.
//   i_fun   : load funct3
//   i_addr  : byte offset of the load address
//   i_data  : raw 32-bit data memory word
//   o_value : register file value
//   Byte loads pick the byte at i_addr, halfword loads the half at i_addr[1];
//   B/H sign-extend, BU/HU zero-extend, everything else passes the word.
module rv_load_align
   import rv_writeback_pkg::*;
(
   input  logic [2:0]  i_fun,
   input  logic [1:0]  i_addr,
   input  logic [31:0] i_data,
   output logic [31:0] o_value
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   always_comb begin
      w_byte = i_data[7:0];
      case (i_addr)
         2'd0:    w_byte = i_data[7:0];
         2'd1:    w_byte = i_data[15:8];
         2'd2:    w_byte = i_data[23:16];
         default: w_byte = i_data[31:24];
      endcase
      // Halfword offset bit 0 is deliberately ignored (misaligned halves
      // are not trapped here).
      w_half = i_addr[1] ? i_data[31:16] : i_data[15:0];
   end

   always_comb begin
      o_value = i_data;
      case (i_fun)
         LDST_B:  o_value = {{24{w_byte[7]}}, w_byte};
         LDST_BU: o_value = {24'h0, w_byte};
         LDST_H:  o_value = {{16{w_half[15]}}, w_half};
         LDST_HU: o_value = {16'h0, w_half};
         default: o_value = i_data;
      endcase
   end

endmodule

// File: rtl/rv_writeback.sv
// rv_writeback
//   Final (W) pipeline stage of the uRV core.
//   clk_i   : core clock, rising edge
//   rst_n_i : asynchronous active-low reset
//   wb      : rv_writeback_if.slave (X stage results, data memory read
//             data, register file write port, W->X bypass, stall, debug state)
//   The W registers capture the X stage whenever the stage is not stalled.
//   A load in W stalls the pipe until dm_load_done_i, then is aligned and
//   written in that same cycle. Loads (and multiplies) never use the early
//   bypass.
//   Optional: RV_WB_MUL_EN selects mul_result_i as the write value for
//   instructions flagged x_mul_i.
module rv_writeback
   import rv_writeback_pkg::*;
(
   input  logic clk_i,
   input  logic rst_n_i,
   rv_writeback_if.slave wb
);

   logic        r_valid;
   logic [4:0]  r_rd;
   logic [31:0] r_value;
   logic        r_write;
   logic        r_load;
   logic [2:0]  r_fun;
   logic [1:0]  r_addr;
`ifdef RV_WB_MUL_EN
   logic        r_mul;
`endif

   wb_state_e   r_state;
   wb_state_e   w_state_nxt;

   logic        w_stall;
   logic        w_store;
   logic        w_bypass;
   logic [31:0] w_load_value;
   logic [31:0] w_rd_value;

   rv_load_align u_align (
      .i_fun   (r_fun),
      .i_addr  (r_addr),
      .i_data  (wb.dm_data_l_i),
      .o_value (w_load_value)
   );

   // W pipeline registers: hold everything while a load waits.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_valid <= 1'b0;
         r_rd    <= 5'd0;
         r_value <= 32'd0;
         r_write <= 1'b0;
         r_load  <= 1'b0;
         r_fun   <= 3'd0;
         r_addr  <= 2'd0;
`ifdef RV_WB_MUL_EN
         r_mul   <= 1'b0;
`endif
      end else if (!w_stall) begin
         r_valid <= wb.x_valid_i;
         r_rd    <= wb.x_rd_i;
         r_value <= wb.x_rd_value_i;
         r_write <= wb.x_rd_write_i;
         r_load  <= wb.x_load_i;
         r_fun   <= wb.x_fun_i;
         r_addr  <= wb.x_dm_addr_i;
`ifdef RV_WB_MUL_EN
         r_mul   <= wb.x_mul_i;
`endif
      end
   end

   // FSM: state register
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) r_state <= ST_IDLE;
      else          r_state <= w_state_nxt;
   end

   // FSM: next state. A load captured while done is already high (the
   // previous load completing) stays in IDLE; stall itself is derived from
   // the W registers, so the state is informational for the debug port.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (!w_stall && wb.x_valid_i && wb.x_load_i && !wb.dm_load_done_i)
               w_state_nxt = ST_LOAD_WAIT;
         end
         ST_LOAD_WAIT: begin
            if (wb.dm_load_done_i)
               w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // FSM: outputs
   always_comb begin
      w_stall  = r_valid & r_load & ~wb.dm_load_done_i;
      w_store  = r_valid & r_write & (~r_load | wb.dm_load_done_i);
`ifdef RV_WB_MUL_EN
      w_bypass = r_valid & r_write & ~r_load & ~r_mul;
`else
      w_bypass = r_valid & r_write & ~r_load;
`endif
      w_rd_value = r_value;
      if (r_load)
         w_rd_value = w_load_value;
`ifdef RV_WB_MUL_EN
      else if (r_mul)
         w_rd_value = wb.mul_result_i;
`endif
   end

   assign wb.w_stall_o         = w_stall;
   assign wb.rf_rd_o           = r_rd;
   assign wb.rf_rd_value_o     = w_rd_value;
   assign wb.rf_rd_store_o     = w_store;
   assign wb.rf_bypass_write_o = w_bypass;
   assign wb.rf_bypass_value_o = r_value;
   assign wb.dbg_state_o       = r_state;

endmodule

// File: tb/tb_rv_writeback.sv
module tb_rv_writeback;
   import rv_writeback_pkg::*;

   logic clk_i = 1'b0;
   logic rst_n_i = 1'b0;
   int   n_assert = 0;
   int   n_fail = 0;

   rv_writeback_if wb_if ();

   rv_writeback dut (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .wb      (wb_if)
   );

   always #5 clk_i = ~clk_i;

   // reference W slot
   logic        m_valid, m_wr, m_ld, m_mul;
   logic [4:0]  m_rd;
   logic [31:0] m_val;
   logic [2:0]  m_fun;
   logic [1:0]  m_addr;

   function automatic logic [31:0] ref_load(input logic [2:0] fun, input logic [1:0] addr,
                                            input logic [31:0] d);
      int unsigned ofs;
      logic [31:0] b, h;
      ofs = addr;
      b = d >> (8 * ofs);
      h = d >> (16 * (ofs / 2));
      case (fun)
         3'd0:    return {{24{b[7]}}, b[7:0]};
         3'd4:    return {24'h0, b[7:0]};
         3'd1:    return {{16{h[15]}}, h[15:0]};
         3'd5:    return {16'h0, h[15:0]};
         default: return d;
      endcase
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_valid = 0; m_wr = 0; m_ld = 0; m_mul = 0;
      m_rd = 0; m_val = 0; m_fun = 0; m_addr = 0;
   endtask

   task automatic put_x(input logic v, input logic [4:0] rd, input logic [31:0] val,
                        input logic wr, input logic ld, input logic [2:0] fun,
                        input logic [1:0] addr, input logic mul);
      wb_if.x_valid_i    = v;
      wb_if.x_rd_i       = rd;
      wb_if.x_rd_value_i = val;
      wb_if.x_rd_write_i = wr;
      wb_if.x_load_i     = ld;
      wb_if.x_fun_i      = fun;
      wb_if.x_dm_addr_i  = addr;
`ifdef RV_WB_MUL_EN
      wb_if.x_mul_i      = mul;
`else
      if (mul) $display("note: multiply flag ignored in this build");
`endif
   endtask

   task automatic bubble();
      put_x(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 3'd0, 2'd0, 1'b0);
   endtask

   task automatic drive_dm(input logic done, input logic [31:0] dmd, input logic [31:0] mres);
      wb_if.dm_load_done_i = done;
      wb_if.dm_data_l_i    = dmd;
`ifdef RV_WB_MUL_EN
      wb_if.mul_result_i   = mres;
`else
      if (mres != 32'd0 && done === 1'bx) $display("note: mul result unused");
`endif
      #1;
   endtask

   task automatic check_outputs();
      logic        done, e_stall;
      logic [31:0] e_val, mres;
      done = wb_if.dm_load_done_i;
`ifdef RV_WB_MUL_EN
      mres = wb_if.mul_result_i;
`else
      mres = 32'd0;
`endif
      e_stall = m_valid & m_ld & ~done;
      e_val = m_ld ? ref_load(m_fun, m_addr, wb_if.dm_data_l_i) : (m_mul ? mres : m_val);
      check("stall", 32'(wb_if.w_stall_o), 32'(e_stall));
      check("store", 32'(wb_if.rf_rd_store_o), 32'(m_valid & m_wr & (~m_ld | done)));
      check("rd", 32'(wb_if.rf_rd_o), 32'(m_rd));
      check("value", wb_if.rf_rd_value_o, e_val);
      check("byp_wr", 32'(wb_if.rf_bypass_write_o), 32'(m_valid & m_wr & ~m_ld & ~m_mul));
      check("byp_val", wb_if.rf_bypass_value_o, m_val);
   endtask

   // Advance one clock and update the reference W slot.
   task automatic clock();
      logic hold;
      hold = m_valid & m_ld & ~wb_if.dm_load_done_i;
      @(posedge clk_i);
      if (!hold) begin
         m_valid = wb_if.x_valid_i;
         m_rd    = wb_if.x_rd_i;
         m_val   = wb_if.x_rd_value_i;
         m_wr    = wb_if.x_rd_write_i;
         m_ld    = wb_if.x_load_i;
         m_fun   = wb_if.x_fun_i;
         m_addr  = wb_if.x_dm_addr_i;
`ifdef RV_WB_MUL_EN
         m_mul   = wb_if.x_mul_i;
`else
         m_mul   = 1'b0;
`endif
      end
      @(negedge clk_i);
   endtask

   task automatic cycle(input logic done, input logic [31:0] dmd, input logic [31:0] mres);
      drive_dm(done, dmd, mres);
      check_outputs();
      clock();
   endtask

   initial begin
      model_reset();
      bubble();
      drive_dm(1'b0, 32'd0, 32'd0);
      repeat (2) @(negedge clk_i);

      // reset state
      check_outputs();
      check("rst_state", 32'(wb_if.dbg_state_o), 32'(ST_IDLE));
      rst_n_i = 1'b1;

      // ALU write x5=0x1234
      put_x(1'b1, 5'd5, 32'h1234, 1'b1, 1'b0, 3'd0, 2'd0, 1'b0);
      cycle(1'b0, 32'd0, 32'd0);
      bubble();
      drive_dm(1'b0, 32'd0, 32'd0);
      check_outputs();
      check("alu_store", 32'(wb_if.rf_rd_store_o), 32'd1);
      check("alu_rd", 32'(wb_if.rf_rd_o), 32'd5);
      check("alu_byp", 32'(wb_if.rf_bypass_write_o), 32'd1);
      clock();

      // LB addr=3, two wait cycles
      put_x(1'b1, 5'd9, 32'h5555_5555, 1'b1, 1'b1, LDST_B, 2'd3, 1'b0);
      cycle(1'b0, 32'd0, 32'd0);
      bubble();
      drive_dm(1'b0, 32'd0, 32'd0);
      check("lb_stall1", 32'(wb_if.w_stall_o), 32'd1);
      check("lb_wait_state", 32'(wb_if.dbg_state_o), 32'(ST_LOAD_WAIT));
      check_outputs();
      clock();
      cycle(1'b0, 32'd0, 32'd0);
      drive_dm(1'b1, 32'h80FF_0000, 32'd0);
      check_outputs();
      check("lb_val", wb_if.rf_rd_value_o, 32'hFFFF_FF80);
      check("lb_byp", 32'(wb_if.rf_bypass_write_o), 32'd0);
      clock();

      // LHU addr=2 then LH addr=0
      put_x(1'b1, 5'd10, 32'd0, 1'b1, 1'b1, LDST_HU, 2'd2, 1'b0);
      cycle(1'b0, 32'd0, 32'd0);
      put_x(1'b1, 5'd11, 32'd0, 1'b1, 1'b1, LDST_H, 2'd0, 1'b0);
      drive_dm(1'b1, 32'h8001_1234, 32'd0);
      check_outputs();
      check("lhu_val", wb_if.rf_rd_value_o, 32'h0000_8001);
      clock();
      bubble();
      drive_dm(1'b1, 32'h0000_F00F, 32'd0);
      check_outputs();
      check("lh_val", wb_if.rf_rd_value_o, 32'hFFFF_F00F);
      clock();

      // two back-to-back LWs completed on arrival
      put_x(1'b1, 5'd12, 32'd0, 1'b1, 1'b1, LDST_W, 2'd0, 1'b0);
      cycle(1'b0, 32'd0, 32'd0);
      put_x(1'b1, 5'd13, 32'd0, 1'b1, 1'b1, LDST_W, 2'd0, 1'b0);
      drive_dm(1'b1, 32'hCAFE_0001, 32'd0);
      check_outputs();
      check("lw1_nostall", 32'(wb_if.w_stall_o), 32'd0);
      check("lw1_store", 32'(wb_if.rf_rd_store_o), 32'd1);
      clock();
      bubble();
      drive_dm(1'b1, 32'hCAFE_0002, 32'd0);
      check_outputs();
      check("lw2_rd", 32'(wb_if.rf_rd_o), 32'd13);
      check("lw2_val", wb_if.rf_rd_value_o, 32'hCAFE_0002);
      clock();
      cycle(1'b1, 32'hDEAD_0000, 32'd0); // stray done, empty W

      // reset in the middle of a load wait
      put_x(1'b1, 5'd14, 32'd0, 1'b1, 1'b1, LDST_W, 2'd0, 1'b0);
      cycle(1'b0, 32'd0, 32'd0);
      bubble();
      cycle(1'b0, 32'd0, 32'd0);
      rst_n_i = 1'b0;
      drive_dm(1'b1, 32'h1111_1111, 32'd0);
      check("rst_stall", 32'(wb_if.w_stall_o), 32'd0);
      check("rst_store", 32'(wb_if.rf_rd_store_o), 32'd0);
      model_reset();
      @(negedge clk_i);
      rst_n_i = 1'b1;
      drive_dm(1'b1, 32'h2222_2222, 32'd0);
      check("stray_store", 32'(wb_if.rf_rd_store_o), 32'd0);
      check_outputs();
      clock();

`ifdef RV_WB_MUL_EN
      put_x(1'b1, 5'd7, 32'h0BAD_0BAD, 1'b1, 1'b0, 3'd0, 2'd0, 1'b1);
      cycle(1'b0, 32'd0, 32'd0);
      bubble();
      drive_dm(1'b0, 32'd0, 32'hDEAD_BEEF);
      check_outputs();
      check("mul_val", wb_if.rf_rd_value_o, 32'hDEAD_BEEF);
      check("mul_byp", 32'(wb_if.rf_bypass_write_o), 32'd0);
      clock();
`endif

      // randomized traffic
      for (int i = 0; i < 300; i++) begin
         logic ld;
         ld = ($urandom_range(0, 9) < 4);
         put_x($urandom_range(0, 9) < 7, 5'($urandom), $urandom, 1'($urandom),
               ld, 3'($urandom), 2'($urandom), ~ld & 1'($urandom));
         cycle($urandom_range(0, 1) == 1, $urandom, $urandom);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
